// File: rtl/lc3b_types.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : lc3b_types                                                    |
// | Purpose    : Shared types for the LC-3b pipeline memory subsystem: the     |
// |              cache-line vector, the memory-arbiter state encoding and the  |
// |              round-robin grant decision used by the arbiter FSM.           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package lc3b_types;

   localparam int LC3B_LINE_WIDTH = 128;

   typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_c_line;

   // Two-bit encoding kept explicit so the values are stable for any
   // downstream logic or waveform tooling that decodes the raw bits.
   typedef enum logic [1:0] {
      arb_idle    = 2'd0,
      arb_serve_i = 2'd1,
      arb_serve_d = 2'd2,
      arb_recover = 2'd3
   } lc3b_arb_state;

   // Grant decision taken from IDLE. On a tie the requester that was not
   // served last wins; last_served is 0 after I, 1 after D.
   function automatic lc3b_arb_state arb_grant(
      input logic i_req,
      input logic d_req,
      input logic last_served
   );
      lc3b_arb_state next;
      next = arb_idle;
      if (i_req && d_req) begin
         next = last_served ? arb_serve_i : arb_serve_d;
      end else if (d_req) begin
         next = arb_serve_d;
      end else if (i_req) begin
         next = arb_serve_i;
      end
      return next;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_arbiter_fsm                                               |
// | Purpose    : Registered grant FSM for the I/D-cache memory arbiter.        |
// |              Holds the current grant and the round-robin history bit.      |
// | Ports      : clk       in   system clock                                   |
// |              reset     in   asynchronous active-high reset                 |
// |              i_req     in   I-cache is requesting a line                   |
// |              d_req     in   D-cache is requesting a read or writeback      |
// |              pmem_resp in   physical memory completion pulse               |
// |              state     out  current arbiter state                          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arbiter_fsm
   import lc3b_types::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic          d_req,
   input  logic          pmem_resp,
   output lc3b_arb_state state
);

   lc3b_arb_state state_q;
   lc3b_arb_state state_d;
   logic          last_served_q;
   logic          last_served_d;

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      case (state_q)
         arb_idle: begin
            state_d = arb_grant(i_req, d_req, last_served_q);
         end
         arb_serve_i: begin
            // A dropped request does not end the grant; only memory does.
            if (pmem_resp) begin
               last_served_d = 1'b0;
               state_d       = arb_recover;
            end
         end
         arb_serve_d: begin
            if (pmem_resp) begin
               last_served_d = 1'b1;
               state_d       = arb_recover;
            end
         end
         arb_recover: begin
            // One dead cycle so a requester that drops on its resp edge is
            // not granted again from a stale request.
            state_d = arb_idle;
         end
         default: begin
            state_d = arb_idle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= arb_idle;
         last_served_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_arbiter                                                   |
// | Purpose    : Shares one physical-memory port between the I-cache and       |
// |              D-cache line paths. Transactions are serialised by a          |
// |              registered grant FSM with round-robin tie-breaking; this      |
// |              level only steers signals according to the current grant.     |
// | Ports      : clk, reset                 clock, async active-high reset     |
// |              i_read/i_address           I-cache line read request          |
// |              i_rdata/i_resp             I-cache return data / done pulse   |
// |              d_read/d_write/d_address   D-cache read / writeback request   |
// |              d_wdata                    D-cache writeback data             |
// |              d_rdata/d_resp             D-cache return data / done pulse   |
// |              pmem_read/pmem_write       physical memory strobes            |
// |              pmem_address/pmem_wdata    physical memory address / data     |
// |              pmem_rdata/pmem_resp       physical memory data / done pulse  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   // I-cache side
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   // D-cache side
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   // Physical memory side
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   lc3b_arb_state state;
   logic          i_req;
   logic          d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   mem_arbiter_fsm u_fsm (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .d_req     (d_req),
      .pmem_resp (pmem_resp),
      .state     (state)
   );

   // Everything is zeroed outside a serve state so a late or spurious
   // pmem_resp can never leak through to either cache.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_rdata      = '0;
      i_resp       = 1'b0;
      d_rdata      = '0;
      d_resp       = 1'b0;
      case (state)
         arb_serve_i: begin
            // Strobe follows the live request so a withdrawn request is
            // visible to memory immediately.
            pmem_read    = i_read;
            pmem_address = i_address;
            i_rdata      = pmem_rdata;
            i_resp       = pmem_resp;
         end
         arb_serve_d: begin
            // Writeback takes precedence if the cache raises both strobes.
            pmem_write   = d_write;
            pmem_read    = d_read & ~d_write;
            pmem_address = d_address;
            pmem_wdata   = d_wdata;
            d_rdata      = pmem_rdata;
            d_resp       = pmem_resp;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_mem_arbiter                                                |
// | Purpose    : Self-checking bench for mem_arbiter. The bench plays the      |
// |              memory; expected transactions are queued when requests are    |
// |              raised and compared when the arbiter completes them.          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
   import lc3b_types::*;

   localparam int AW = 16;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   typedef struct {
      logic          is_d;
      logic [AW-1:0] addr;
      logic          rd;
      logic          wr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
   } exp_t;

   typedef struct {
      logic          timeout;
      int            wait_cyc;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic          ir;
      logic          dr;
      logic [LW-1:0] rdata;
   } obs_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW+3:0] hs(input logic ir, input logic dr,
                                        input logic rd, input logic wr,
                                        input logic [AW-1:0] a);
      return {ir, dr, rd, wr, a};
   endfunction

   // Memory model: waits (bounded) for a strobe, holds for lat serve
   // cycles, then pulses pmem_resp with data and records what it saw.
   task automatic mem_txn(input int lat, input logic [LW-1:0] data, output obs_t o);
      o.timeout = 1'b0; o.wait_cyc = 0; o.rd = 1'b0; o.wr = 1'b0;
      o.addr = '0; o.wdata = '0; o.ir = 1'b0; o.dr = 1'b0; o.rdata = '0;
      while (!(pmem_read || pmem_write) && o.wait_cyc < 20) begin
         cyc();
         o.wait_cyc++;
      end
      if (!(pmem_read || pmem_write)) begin
         o.timeout = 1'b1;
         return;
      end
      o.rd = pmem_read; o.wr = pmem_write; o.addr = pmem_address; o.wdata = pmem_wdata;
      for (int k = 1; k < lat; k++) cyc();
      pmem_rdata = data;
      pmem_resp  = 1'b1;
      #1;
      o.ir = i_resp; o.dr = d_resp;
      o.rdata = d_resp ? d_rdata : i_rdata;
      cyc();
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0;
      d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
      reset = 1'b1;
      cyc(); cyc();
      tests++;
      if ({pmem_read, pmem_write, i_resp, d_resp, pmem_address} !== '0 || dut.state !== arb_idle) begin
         fails++;
         $display("FAIL reset_outputs: got strobes/resps/addr=%h state=%0d, required 0 and IDLE",
                  {pmem_read, pmem_write, i_resp, d_resp, pmem_address}, dut.state);
      end
      reset = 1'b0;
      cyc();
      d_write = 1'b1; d_address = 16'h0BEE; d_wdata = {4{32'hA5A5_0F0F}};
      cyc();
      tests++;
      if (pmem_write !== 1'b1) begin
         fails++;
         $display("FAIL reset_pre_write: pmem_write=%b, required 1", pmem_write);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (pmem_write !== 1'b0 || dut.state !== arb_idle) begin
         fails++;
         $display("FAIL reset_midtxn: pmem_write=%b state=%0d, required 0 and IDLE", pmem_write, dut.state);
      end
      cyc();
      reset = 1'b0; d_write = 1'b0;
      pmem_resp = 1'b1; pmem_rdata = {4{32'h1111_2222}};
      #1;
      tests++;
      if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
         fails++;
         $display("FAIL reset_late_resp: d_resp=%b i_resp=%b, required 0 0", d_resp, i_resp);
      end
      cyc();
      pmem_resp = 1'b0; pmem_rdata = '0;
      tests++;
      if (dut.state !== arb_idle) begin
         fails++;
         $display("FAIL reset_late_resp_state: state=%0d, required IDLE", dut.state);
      end
   endtask

   task automatic test_lone_i();
      obs_t o; exp_t e;
      logic [LW-1:0] dat;
      dat = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      i_read = 1'b1; i_address = 16'h0040;
      sb_q.push_back(exp_t'{is_d: 1'b0, addr: 16'h0040, rd: 1'b1, wr: 1'b0, wdata: '0, rdata: dat});
      cyc();
      tests++;
      if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, 16'h0040}) begin
         fails++;
         $display("FAIL lone_i_grant: rd/wr/addr=%h, required %h",
                  {pmem_read, pmem_write, pmem_address}, {1'b1, 1'b0, 16'h0040});
      end
      mem_txn(5, dat, o);
      e = sb_q.pop_front();
      tests++;
      if (o.timeout || hs(o.ir, o.dr, o.rd, o.wr, o.addr) !== hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr)
          || o.rdata !== e.rdata) begin
         fails++;
         $display("FAIL lone_i_txn: to=%b hs=%h data=%h, required hs=%h data=%h", o.timeout,
                  hs(o.ir, o.dr, o.rd, o.wr, o.addr), o.rdata, hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr), e.rdata);
      end
      tests++;
      if ({i_resp, pmem_read} !== 2'b00) begin
         fails++;
         $display("FAIL lone_i_after: i_resp/pmem_read=%b, required 00", {i_resp, pmem_read});
      end
      i_read = 1'b0;
      cyc();
   endtask

   task automatic test_lone_d();
      obs_t o; exp_t e;
      logic [LW-1:0] wd;
      wd = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      d_write = 1'b1; d_address = 16'h1230; d_wdata = wd;
      sb_q.push_back(exp_t'{is_d: 1'b1, addr: 16'h1230, rd: 1'b0, wr: 1'b1, wdata: wd, rdata: {4{32'h7777_8888}}});
      mem_txn(3, {4{32'h7777_8888}}, o);
      e = sb_q.pop_front();
      tests++;
      if (o.timeout || hs(o.ir, o.dr, o.rd, o.wr, o.addr) !== hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr)
          || o.wdata !== e.wdata) begin
         fails++;
         $display("FAIL lone_d_txn: to=%b hs=%h wdata=%h, required hs=%h wdata=%h", o.timeout,
                  hs(o.ir, o.dr, o.rd, o.wr, o.addr), o.wdata, hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr), e.wdata);
      end
      tests++;
      if ({d_resp, i_resp, pmem_write} !== 3'b000) begin
         fails++;
         $display("FAIL lone_d_after: d_resp/i_resp/pmem_write=%b, required 000", {d_resp, i_resp, pmem_write});
      end
      d_write = 1'b0;
      cyc();
   endtask

   task automatic test_simultaneous();
      obs_t o; exp_t e;
      pulse_reset();
      i_read = 1'b1; i_address = 16'h0100;
      d_read = 1'b1; d_address = 16'h2200;
      sb_q.push_back(exp_t'{is_d: 1'b1, addr: 16'h2200, rd: 1'b1, wr: 1'b0, wdata: '0, rdata: {4{32'hD0D0_0001}}});
      sb_q.push_back(exp_t'{is_d: 1'b0, addr: 16'h0100, rd: 1'b1, wr: 1'b0, wdata: '0, rdata: {4{32'h1010_0002}}});
      sb_q.push_back(exp_t'{is_d: 1'b1, addr: 16'h2200, rd: 1'b1, wr: 1'b0, wdata: '0, rdata: {4{32'hD0D0_0003}}});
      for (int t = 0; t < 3; t++) begin
         mem_txn(1 + t, {4{(t == 1) ? 32'h1010_0002 : (32'hD0D0_0001 + 32'(t))}}, o);
         e = sb_q.pop_front();
         tests++;
         if (o.timeout || hs(o.ir, o.dr, o.rd, o.wr, o.addr) !== hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr)
             || o.rdata !== e.rdata) begin
            fails++;
            $display("FAIL simul_txn%0d: to=%b hs=%h data=%h, required hs=%h data=%h", t, o.timeout,
                     hs(o.ir, o.dr, o.rd, o.wr, o.addr), o.rdata, hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr), e.rdata);
         end
         if (t == 1) begin
            tests++;
            if (o.wait_cyc !== 2) begin
               fails++;
               $display("FAIL simul_gap: I grant after %0d cycles, required 2", o.wait_cyc);
            end
         end
         d_read = (t == 1);
      end
      i_read = 1'b0; d_read = 1'b0;
      cyc();
   endtask

   task automatic test_starvation();
      obs_t o; exp_t e;
      logic [LW-1:0] dat;
      logic          want_d;
      pulse_reset();
      i_read = 1'b1; i_address = 16'h0300;
      d_read = 1'b1; d_address = 16'h4400;
      for (int k = 0; k < 10; k++) begin
         want_d = (k % 2 == 0);
         dat = {4{32'h0101_0101 * 32'(k + 1)}};
         sb_q.push_back(exp_t'{is_d: want_d, addr: want_d ? 16'h4400 : 16'h0300, rd: 1'b1, wr: 1'b0,
                               wdata: '0, rdata: dat});
         mem_txn(1 + (k % 3), dat, o);
         e = sb_q.pop_front();
         tests++;
         if (o.timeout || hs(o.ir, o.dr, o.rd, o.wr, o.addr) !== hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr)
             || o.rdata !== e.rdata || o.wait_cyc !== ((k == 0) ? 1 : 2)) begin
            fails++;
            $display("FAIL starve_txn%0d: to=%b hs=%h data=%h wait=%0d, required hs=%h data=%h wait=%0d",
                     k, o.timeout, hs(o.ir, o.dr, o.rd, o.wr, o.addr), o.rdata, o.wait_cyc,
                     hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr), e.rdata, (k == 0) ? 1 : 2);
         end
      end
      i_read = 1'b0; d_read = 1'b0;
      cyc();
   endtask

   task automatic test_spurious();
      obs_t o; exp_t e;
      logic [LW-1:0] wd;
      pmem_resp = 1'b1; pmem_rdata = {4{32'hBAD0_BAD0}};
      #1;
      tests++;
      if ({i_resp, d_resp} !== 2'b00 || i_rdata !== '0 || d_rdata !== '0) begin
         fails++;
         $display("FAIL spur_idle: i_resp/d_resp=%b i_rdata=%h d_rdata=%h, required 00 and zero data",
                  {i_resp, d_resp}, i_rdata, d_rdata);
      end
      cyc();
      pmem_resp = 1'b0; pmem_rdata = '0;
      tests++;
      if (dut.state !== arb_idle) begin
         fails++;
         $display("FAIL spur_idle_state: state=%0d, required IDLE", dut.state);
      end
      wd = {4{32'hC0DE_F00D}};
      d_read = 1'b1; d_write = 1'b1; d_address = 16'h5670; d_wdata = wd;
      sb_q.push_back(exp_t'{is_d: 1'b1, addr: 16'h5670, rd: 1'b0, wr: 1'b1, wdata: wd, rdata: '0});
      mem_txn(2, '0, o);
      e = sb_q.pop_front();
      tests++;
      if (o.timeout || hs(o.ir, o.dr, o.rd, o.wr, o.addr) !== hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr)
          || o.wdata !== e.wdata) begin
         fails++;
         $display("FAIL both_rw: to=%b hs=%h wdata=%h, required hs=%h wdata=%h", o.timeout,
                  hs(o.ir, o.dr, o.rd, o.wr, o.addr), o.wdata, hs(~e.is_d, e.is_d, e.rd, e.wr, e.addr), e.wdata);
      end
      d_read = 1'b0; d_write = 1'b0;
      pmem_resp = 1'b1;
      #1;
      tests++;
      if ({i_resp, d_resp} !== 2'b00) begin
         fails++;
         $display("FAIL spur_recover: i_resp/d_resp=%b, required 00", {i_resp, d_resp});
      end
      cyc();
      pmem_resp = 1'b0;
      tests++;
      if (dut.state !== arb_idle) begin
         fails++;
         $display("FAIL spur_recover_state: state=%0d, required IDLE", dut.state);
      end
   endtask

   initial begin
      test_reset();
      test_lone_i();
      test_lone_d();
      test_simultaneous();
      test_starvation();
      test_spurious();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
